keccak_byte_packer: RTL and testbench
=====================================

Name: keccak_byte_packer

Overview:
Upstream feeder for the Keccak controller. Accepts a byte stream with valid/ready/last framing from the CPU-side message buffer and packs it big-endian into 32-bit words. Drives the controller's word interface (keccak_en, keccak_data32, is_last) and reports how many bytes of the final word are valid, so the controller applies padding at the right position.

Parameters:
WCNT_W, 16, width of per-message emitted-word counter.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-high.
in_valid  in  1  byte present on in_data.
in_data  in  8  message byte.
in_keep  in  1  in_data is a real byte; 0 only with in_last=1 (terminate without a byte, e.g. empty message).
in_last  in  1  final beat of the message.
in_ready  out  1  packer accepts a beat this cycle.
keccak_busy  in  1  controller is permuting and cannot take new words.
keccak_en  out  1  one-cycle strobe: keccak_data32 is valid.
keccak_data32  out  32  packed word; first byte in [31:24].
is_last  out  1  coincides with keccak_en on the final word of the message.
byte_num  out  2  valid bytes in the final word (0..3); 0 when is_last=0.
word_cnt  out  WCNT_W  words emitted for the current message.

Behaviour:
- Reset: all outputs 0, acc=0, cnt=0, state=ACC. Reset mid-message discards partial data; next beat after reset starts a new message.
- A beat is accepted when in_valid && in_ready. in_ready = !rst && !keccak_busy && state==ACC.
- Internal state: acc[23:0] holds up to 3 bytes; cnt[1:0] is the number held.
- Accepted beat with in_keep=1 and in_last=0:
  - cnt<3: store the byte in acc slot cnt, cnt++.
  - cnt==3: next cycle keccak_en=1, keccak_data32={acc,in_data}, is_last=0. Then cnt=0, acc=0.
- Accepted beat with in_last=1. Let n = cnt + in_keep (n is 0..4).
  - n<4: next cycle keccak_en=1, is_last=1, byte_num=n. keccak_data32 holds the n bytes left-aligned; unused low bytes are 0.
  - n==4: next cycle emit the full word with is_last=0. State goes to FLUSH.
  - FLUSH: the following cycle emits keccak_data32=0, is_last=1, byte_num=0. The zero final word is mandatory for messages whose length is a multiple of 4. FLUSH then returns to ACC.
- Latency: output strobe is exactly 1 cycle after the completing beat. All outputs are registered.
- keccak_en, is_last and byte_num are single-cycle pulses. keccak_data32 holds its value until the next strobe.
- The controller must accept any word strobed by keccak_en. keccak_busy only gates input acceptance. A word registered in the cycle busy rises is still delivered.
- FLUSH ignores keccak_busy; the controller contract accepts one trailing word.
- word_cnt increments on every keccak_en. It clears to 0 on the cycle after the is_last strobe.
- Back-to-back messages: a new message's first beat may be accepted the cycle after the is_last strobe (ACC, cnt=0).
- in_valid with in_keep=0 and in_last=0 is illegal. The beat is dropped and state is unchanged.

Decomposition:
- Add localparam state encodings (ST_ACC, ST_FLUSH) and the byte_num width to the shared keccak definitions package used by the controller.
- No sub-module. Byte-lane insert and left-align are one always block. The FSM and word counter fit in about 150 lines.

Test Plan:
- "The quick brown fox jumps over the lazy dog." (44 bytes, last on '.') -> 11 strobes. First word 0x54686520 ("The "), 11th 0x646F672E ("dog."), then a 12th strobe of 0x00000000 with is_last=1, byte_num=0. word_cnt reaches 12 then clears.
- "abc" (in_last on 'c') -> one strobe 0x61626300, is_last=1, byte_num=3.
- Empty message: single beat in_keep=0, in_last=1 -> one strobe 0x00000000, is_last=1, byte_num=0.
- keccak_busy held high for 5 cycles after byte 4 of "abcdefgh" -> in_ready=0 for those cycles and no beats accepted. After busy falls, word 0x65666768 follows, then the FLUSH zero word.
- rst pulse after 6 bytes of a message, then "xy" + last -> no strobe from the partial data. Single strobe 0x78790000, byte_num=2, word_cnt=1.
- Two messages back-to-back ("abcd", "e") -> strobes 0x61626364, 0x00000000 (last, 0), 0x65000000 (last, 1). No dropped beats.

Source files
------------

// File: rtl/keccak_byte_packer_pkg.sv
// Shared keccak definitions: packer FSM states
// and the final-word byte-count width.
package keccak_byte_packer_pkg;

  localparam int BNUM_W = 2;

  typedef enum logic {
    ST_ACC   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/keccak_byte_packer.sv
// Packs a framed byte stream big-endian into
// 32-bit words for the keccak controller.
module keccak_byte_packer
  import keccak_byte_packer_pkg::*;
#(
  parameter int WCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_keep,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              keccak_busy,
  output logic              keccak_en,
  output logic [31:0]       keccak_data32,
  output logic              is_last,
  output logic [BNUM_W-1:0] byte_num,
  output logic [WCNT_W-1:0] word_cnt
);

  state_e              state_q, state_d;
  logic [23:0]         acc_q, acc_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                en_q, en_d;
  logic [31:0]         data_q, data_d;
  logic                last_q, last_d;
  logic [BNUM_W-1:0]   bnum_q, bnum_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;

  logic                accept;
  logic [2:0]          n;
  logic [4:0]          shamt;
  logic [31:0]         word;

  assign in_ready = !rst && !keccak_busy &&
                    (state_q == ST_ACC);

  always_comb begin
    accept = in_valid && in_ready;
    n      = {1'b0, cnt_q} + {2'b00, in_keep};
    shamt  = 5'd24 - {cnt_q, 3'b000};
    // held bytes already left-aligned; drop the
    // new byte into lane cnt, unused lanes stay 0
    word   = {acc_q, 8'h00};
    if (in_keep) begin
      word = word | ({24'h0, in_data} << shamt);
    end

    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    data_d  = data_q;
    last_d  = 1'b0;
    bnum_d  = '0;

    unique case (state_q)
      ST_FLUSH: begin
        en_d    = 1'b1;
        data_d  = 32'h0;
        last_d  = 1'b1;
        state_d = ST_ACC;
      end
      default: begin
        if (accept && in_last) begin
          en_d   = 1'b1;
          data_d = word;
          acc_d  = '0;
          cnt_d  = '0;
          if (n == 3'd4) begin
            state_d = ST_FLUSH;
          end else begin
            last_d = 1'b1;
            bnum_d = n[1:0];
          end
        end else if (accept && in_keep) begin
          if (cnt_q == 2'd3) begin
            en_d   = 1'b1;
            data_d = word;
            acc_d  = '0;
            cnt_d  = '0;
          end else begin
            acc_d = word[31:8];
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
    endcase

    // count restarts once the final word is out
    wcnt_d = (last_q ? '0 : wcnt_q) +
             WCNT_W'(en_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      bnum_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      data_q  <= data_d;
      last_q  <= last_d;
      bnum_q  <= bnum_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign keccak_en     = en_q;
  assign keccak_data32 = data_q;
  assign is_last       = last_q;
  assign byte_num      = bnum_q;
  assign word_cnt      = wcnt_q;

endmodule

// File: tb/tb_keccak_byte_packer.sv
// Scoreboard bench: byte-queue reference model
// feeds expected words to a forked monitor.
module tb_keccak_byte_packer;

  localparam int WCNT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_keep;
  logic              in_last;
  logic              in_ready;
  logic              keccak_busy;
  logic              keccak_en;
  logic [31:0]       keccak_data32;
  logic              is_last;
  logic [1:0]        byte_num;
  logic [WCNT_W-1:0] word_cnt;

  keccak_byte_packer #(.WCNT_W(WCNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_keep      (in_keep),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .keccak_busy  (keccak_busy),
    .keccak_en    (keccak_en),
    .keccak_data32(keccak_data32),
    .is_last      (is_last),
    .byte_num     (byte_num),
    .word_cnt     (word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [1:0]  b;
    int          w;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  cur[$];
  int          mwc;
  int          cmps;
  int          errs;
  bit          rnd_busy;

  function automatic logic [31:0]
      pack(input logic [7:0] b[$]);
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < b.size(); i++) begin
      w = w + (32'(b[i]) << (24 - 8 * i));
    end
    return w;
  endfunction

  // message-level rules: every 4 bytes make a word;
  // the end of a message always yields a final word
  // holding the leftover 0..3 bytes
  task automatic model_beat(input logic [7:0] d,
                            input logic k,
                            input logic l);
    exp_t e;
    if (k) cur.push_back(d);
    if (cur.size() == 4) begin
      mwc++;
      e.d = pack(cur); e.l = 1'b0;
      e.b = 2'd0;      e.w = mwc;
      exp_q.push_back(e);
      cur.delete();
    end
    if (l) begin
      mwc++;
      e.d = pack(cur); e.l = 1'b1;
      e.b = 2'(cur.size()); e.w = mwc;
      exp_q.push_back(e);
      cur.delete();
      mwc = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rnd_busy)
      keccak_busy = ($urandom_range(0, 3) == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic beat(input logic [7:0] d,
                      input logic k,
                      input logic l);
    int t;
    t = 0;
    tick();
    in_valid = 1'b1; in_data = d;
    in_keep  = k;    in_last = l;
    #1;
    while (!in_ready && t < 200) begin
      t++;
      tick();
      #1;
    end
    if (!in_ready) begin
      cmps++; errs++;
      $display("FAIL beat_timeout ready=%b need 1",
               in_ready);
      in_valid = 1'b0;
    end else begin
      model_beat(d, k, l);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic send_bytes(input logic [7:0] m[$],
                            input bit gap);
    if (m.size() == 0) begin
      beat(8'($urandom), 1'b0, 1'b1);
    end else begin
      for (int i = 0; i < m.size(); i++) begin
        if (gap) idle($urandom_range(0, 2));
        beat(m[i], 1'b1, i == m.size() - 1);
      end
    end
  endtask

  task automatic send_str(input string s);
    logic [7:0] m[$];
    for (int i = 0; i < s.len(); i++)
      m.push_back(s[i]);
    send_bytes(m, 1'b0);
  endtask

  task automatic chk_idle_out(input string nm);
    cmps++;
    if ({keccak_en, keccak_data32, is_last,
         byte_num, word_cnt, in_ready} != '0) begin
      errs++;
      $display("FAIL %s en=%b d=%h l=%b b=%0d wc=%0d rdy=%b need all 0",
               nm, keccak_en, keccak_data32, is_last,
               byte_num, word_cnt, in_ready);
    end
  endtask

  initial begin
    exp_t        e;
    bit          prev_last;
    logic [7:0]  m[$];
    string       s;

    cmps = 0; errs = 0; mwc = 0;
    rnd_busy = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    in_keep = 1'b0; in_last = 1'b0;
    keccak_busy = 1'b0;

    fork
      begin
        prev_last = 1'b0;
        forever begin
          @(negedge clk);
          if (rst) begin
            prev_last = 1'b0;
          end else if (keccak_en) begin
            cmps++;
            if (exp_q.size() == 0) begin
              errs++;
              $display("FAIL extra_strobe d=%h l=%b need none",
                       keccak_data32, is_last);
            end else begin
              e = exp_q.pop_front();
              if (keccak_data32 !== e.d ||
                  is_last !== e.l ||
                  byte_num !== e.b ||
                  word_cnt !== WCNT_W'(e.w)) begin
                errs++;
                $display("FAIL strobe got d=%h l=%b b=%0d wc=%0d need d=%h l=%b b=%0d wc=%0d",
                         keccak_data32, is_last,
                         byte_num, word_cnt,
                         e.d, e.l, e.b, e.w);
              end
            end
            prev_last = is_last;
          end else begin
            cmps++;
            if (is_last !== 1'b0 ||
                byte_num !== 2'd0 ||
                (prev_last && word_cnt !== '0)) begin
              errs++;
              $display("FAIL quiet l=%b b=%0d wc=%0d prev_last=%b need 0",
                       is_last, byte_num, word_cnt,
                       prev_last);
            end
            prev_last = 1'b0;
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk_idle_out("reset_state");
    rst = 1'b0;
    idle(2);

    s = "The quick brown fox jumps over the lazy dog.";
    send_str(s);
    idle(3);
    send_str("abc");
    idle(2);
    send_bytes(m, 1'b0);
    idle(2);

    send_str("abcd");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      keccak_busy = 1'b1;
      in_valid = 1'b1; in_data = 8'h65;
      in_keep = 1'b1;  in_last = 1'b0;
      #1;
      cmps++;
      if (in_ready !== 1'b0) begin
        errs++;
        $display("FAIL busy_ready got %b need 0",
                 in_ready);
      end
    end
    @(negedge clk);
    keccak_busy = 1'b0;
    in_valid = 1'b0;
    send_str("efgh");
    idle(3);

    for (int i = 0; i < 6; i++)
      beat(8'h61 + 8'(i), 1'b1, 1'b0);
    idle(3);
    @(negedge clk);
    rst = 1'b1;
    cur.delete();
    mwc = 0;
    @(negedge clk);
    chk_idle_out("mid_reset");
    rst = 1'b0;
    send_str("xy");
    idle(3);

    send_str("abcd");
    send_str("e");
    idle(3);

    rnd_busy = 1'b1;
    for (int k = 0; k < 30; k++) begin
      m.delete();
      for (int i = 0; i < $urandom_range(0, 13); i++)
        m.push_back(8'($urandom));
      send_bytes(m, 1'b1);
      if ($urandom_range(0, 1) == 1)
        beat(8'($urandom), 1'b0, 1'b0);
    end
    rnd_busy = 1'b0;
    keccak_busy = 1'b0;
    idle(10);

    cmps++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL missing_strobes left=%0d need 0",
               exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmps, errs);
    $finish;
  end

endmodule
